// File: rtl/reg_file_ab_pkg.sv
// Shared CPU constants: architectural register indices and the stack pointer
// reset value, common to the register file and the register-destination mux.
package reg_file_ab_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam int unsigned SP_RESET_DEFAULT = 227;

endpackage

// File: rtl/reg_file_ab_reg_load.sv
// Load-enable register with asynchronous active-low clear; holds the A or B
// operand captured from the register file.
module reg_load #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_ab.sv
// 32-entry register file with two combinational read ports, one write port and
// registered A/B operand outputs that see a same-edge write (write-first).
module reg_file_ab
  import reg_file_ab_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter int unsigned SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              load_ab,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;

  assign wr_en = reg_write && (write_reg != ADDR_W'(REG_ZERO));

  // NOTE: the array is reset explicitly because $sp must come up at SP_RESET;
  // this keeps it in flops rather than a RAM macro, which is intended here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == REG_SP) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // Read ports show pre-edge contents; r0 is forced to zero on read as well.
  assign read_data1 = (read_reg1 == ADDR_W'(REG_ZERO)) ? '0 : regs[read_reg1];
  assign read_data2 = (read_reg2 == ADDR_W'(REG_ZERO)) ? '0 : regs[read_reg2];

  // Operand capture forwards a same-edge write; a match on r0 falls through
  // to the read path, which already yields zero.
  // NOTE: each comb output gets a default first so no latch can be inferred.
  always_comb begin
    a_next = read_data1;
    b_next = read_data2;
    if (wr_en && (write_reg == read_reg1)) a_next = write_data;
    if (wr_en && (write_reg == read_reg2)) b_next = write_data;
  end

  reg_load #(.DATA_W(DATA_W)) u_a (
    .clk   (clk),
    .reset (reset),
    .load  (load_ab),
    .d     (a_next),
    .q     (a_out)
  );

  reg_load #(.DATA_W(DATA_W)) u_b (
    .clk   (clk),
    .reset (reset),
    .load  (load_ab),
    .d     (b_next),
    .q     (b_out)
  );

endmodule

// File: tb/tb_reg_file_ab.sv
// Randomized scoreboard bench for reg_file_ab: a driver updates an array model
// and queues expectations; a negedge monitor pops and compares.
module tb_reg_file_ab;
  import reg_file_ab_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic        load_ab = 1'b0;
  logic [31:0] read_data1, read_data2, a_out, b_out;

  always #5 clk = ~clk;

  reg_file_ab dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .load_ab    (load_ab),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .a_out      (a_out),
    .b_out      (b_out)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;

  // Reference model: architectural register contents and operand latches.
  logic [31:0] m_regs [32];
  logic [31:0] m_a, m_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : m_regs[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == REG_SP) ? 32'd227 : 32'd0;
    m_a = '0;
    m_b = '0;
  endtask

  // One cycle of stimulus: drive just after the edge, queue what the monitor
  // must see mid-cycle, then advance the model to the state after the next edge.
  task automatic cycle(input string tag, input logic rst_v, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic ld);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v; reg_write = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; load_ab = ld;
    if (!rst_v) m_reset();
    e.tag = tag; e.rd1 = m_rd(r1); e.rd2 = m_rd(r2); e.a = m_a; e.b = m_b;
    sb.push_back(e);
    if (rst_v) begin
      if (ld) begin
        m_a = (we && wr != 0 && wr == r1) ? wd : m_rd(r1);
        m_b = (we && wr != 0 && wr == r2) ? wd : m_rd(r2);
      end
      if (we && wr != 0) m_regs[wr] = wd;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".rd1"}, read_data1, e.rd1);
      check({e.tag, ".rd2"}, read_data2, e.rd2);
      check({e.tag, ".a"},   a_out,      e.a);
      check({e.tag, ".b"},   b_out,      e.b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we, ld;
    logic [4:0]  wr, r1, r2;
    logic [31:0] wd;

    m_reset();
    // Reset state, including a write attempt that must be discarded.
    cycle("rst_sp",  1'b0, 1'b1, 5'd1, 32'h1234_5678, 5'd29, 5'd0,  1'b1);
    cycle("rst_r1",  1'b0, 1'b0, 5'd0, 32'h0,         5'd1,  5'd31, 1'b0);
    cycle("rst_rel", 1'b1, 1'b0, 5'd0, 32'h0,         5'd29, 5'd1,  1'b0);

    // Write r8 then read combinationally and capture into A.
    cycle("wr8",     1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
    cycle("rd8",     1'b1, 1'b0, 5'd0, 32'h0,         5'd8, 5'd8, 1'b1);
    cycle("a8",      1'b1, 1'b0, 5'd0, 32'h0,         5'd8, 5'd0, 1'b0);

    // r0 protection, including the bypass path.
    cycle("wr0",     1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1);
    cycle("rd0",     1'b1, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b0);

    // Write-first bypass into B, pre-edge read still old.
    cycle("wr5",     1'b1, 1'b1, 5'd5, 32'd1,         5'd0, 5'd0, 1'b0);
    cycle("byp5",    1'b1, 1'b1, 5'd5, 32'd7,         5'd5, 5'd5, 1'b1);
    cycle("b5",      1'b1, 1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 1'b0);

    // jal / stack destinations; r30 untouched.
    cycle("wr31",    1'b1, 1'b1, 5'(REG_RA), 32'h40,  5'd0, 5'd0, 1'b0);
    cycle("wr29",    1'b1, 1'b1, 5'(REG_SP), 32'd223, 5'd0, 5'd0, 1'b0);
    cycle("rdra",    1'b1, 1'b0, 5'd0, 32'h0,         5'd31, 5'd29, 1'b1);
    cycle("rd30",    1'b1, 1'b0, 5'd0, 32'h0,         5'd30, 5'd29, 1'b0);

    // Reset between two writes to r29.
    cycle("mid_w1",  1'b1, 1'b1, 5'd29, 32'd100,      5'd29, 5'd31, 1'b1);
    cycle("mid_rst", 1'b0, 1'b1, 5'd29, 32'd200,      5'd29, 5'd31, 1'b1);
    cycle("mid_rel", 1'b1, 1'b0, 5'd0,  32'h0,        5'd29, 5'd31, 1'b0);

    // Random traffic, biased toward index collisions and occasional reset.
    for (int n = 0; n < 500; n++) begin
      we = ($urandom_range(0, 3) != 0);
      ld = $urandom_range(0, 1) == 1;
      wr = 5'($urandom_range(0, 31));
      wd = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wr = 5'($urandom_range(0, 3));
      cycle("rnd", ($urandom_range(0, 63) != 0), we, wr, wd, r1, r2, ld);
    end

    repeat (3) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_ab.md
REG_FILE_AB -- requirements
Module: reg_file_ab

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have parameter SP_RESET, default 227, reset value of register 29 ($sp).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port reg_write  input  1  write enable for the write port.
REQ-007 SHALL have port write_reg  input  ADDR_W  destination index, driven by the register-destination mux (rt, rd, 31, 29, rs).
REQ-008 SHALL have port write_data  input  DATA_W  value to write.
REQ-009 SHALL have port read_reg1  input  ADDR_W  rs index.
REQ-010 SHALL have port read_reg2  input  ADDR_W  rt index.
REQ-011 SHALL have port load_ab  input  1  capture enable for the A/B operand registers.
REQ-012 SHALL have port read_data1  output  DATA_W  combinational read of read_reg1.
REQ-013 SHALL have port read_data2  output  DATA_W  combinational read of read_reg2.
REQ-014 SHALL have port a_out  output  DATA_W  registered operand A.
REQ-015 SHALL have port b_out  output  DATA_W  registered operand B.

Function
REQ-016 SHALL write write_data into register write_reg on a rising clk edge when reg_write=1 and write_reg!=0.
REQ-017 SHALL ignore writes to register 0; register 0 SHALL always read 0.
REQ-018 SHALL hold all registers unchanged when reg_write=0.
REQ-019 SHALL drive read_data1/read_data2 combinationally from the array, zero latency, pre-edge contents (no write-through on these ports).
REQ-020 SHALL load a_out/b_out with the register values selected by read_reg1/read_reg2 on a rising edge when load_ab=1, one-cycle latency; hold otherwise.
REQ-021 SHALL, when load_ab=1, reg_write=1 and write_reg equals read_reg1 (nonzero) in the same cycle, load a_out with write_data (write-first bypass); same rule for read_reg2 and b_out.
REQ-022 SHALL, when write_reg=0 under a bypass match, load 0 into a_out/b_out.
REQ-023 SHALL allow read_reg1=read_reg2; both outputs then carry the same value.
REQ-024 SHALL treat all values as unsigned bit patterns; no arithmetic, no truncation.

Reset
REQ-025 SHALL, on reset low, immediately clear all registers to 0 except register 29, set to SP_RESET.
REQ-026 SHALL, on reset low, clear a_out and b_out to 0.
REQ-027 SHALL discard any write or load_ab capture coinciding with reset assertion; reset deasserting mid-cycle takes effect at the next rising edge.

Structure
REQ-028 SHALL take REG_ZERO=0, REG_SP=29, REG_RA=31 and the SP_RESET default from the shared CPU constants package, also used by the register-destination mux.
REQ-029 SHALL implement A and B with one sub-module, reg_load (DATA_W-wide load-enable register, async active-low clear), instantiated twice.

Verification
REQ-030 SHALL cover reset: reset low -> read_data of r29=227, r0/r1/r31=0, a_out=b_out=0.
REQ-031 SHALL cover write/read: write r8=0xDEADBEEF, then read_reg1=8 -> read_data1=0xDEADBEEF same cycle; load_ab -> a_out=0xDEADBEEF next edge.
REQ-032 SHALL cover r0 protection: write r0=0xFFFFFFFF -> read_data1 (read_reg1=0)=0; bypass to a_out gives 0.
REQ-033 SHALL cover bypass: r5=1, same edge reg_write r5=7 and load_ab with read_reg2=5 -> b_out=7, read_data2 before edge=1.
REQ-034 SHALL cover jal/stack destinations: write_reg=31 data 0x40, write_reg=29 data 223 -> r31=0x40, r29=223; r30 unchanged.
REQ-035 SHALL cover reset mid-operation: assert reset between two writes to r29 -> r29=227 after reset, a_out=0, no late write.
